// File: rtl/pipe_chain_pkg.sv
// Shared helpers and types for the pipe_chain pipeline-register block.
// Holds width helpers and the per-stage event priority encoding.
package pipe_chain_pkg;

    // Encoding ranks coincident events: reset beats flush, flush beats stall.
    typedef enum logic [1:0] {
        ACT_PASS  = 2'd0,
        ACT_HOLD  = 2'd1,
        ACT_KILL  = 2'd2,
        ACT_RESET = 2'd3
    } stage_act_e;

    function automatic int unsigned clog2_f(input int unsigned value);
        int unsigned result;
        result = 32'd0;
        for (int unsigned i = 32'd0; i < 32'd32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 32'd1;
            end
        end
        return result;
    endfunction

    function automatic int unsigned occ_width(input int unsigned stages);
        return clog2_f(stages + 32'd1);
    endfunction

    function automatic stage_act_e stage_action(input logic rst, input logic kill,
                                                input logic hold);
        stage_act_e act;
        if (rst) begin
            act = ACT_RESET;
        end else if (kill) begin
            act = ACT_KILL;
        end else if (hold) begin
            act = ACT_HOLD;
        end else begin
            act = ACT_PASS;
        end
        return act;
    endfunction

endpackage

// File: rtl/pipe_chain_stage.sv
// One pipeline slot: valid bit plus payload with hold, load and kill controls.
// Payload only changes on a real load so bubbles do not toggle the data flops.
module pipe_chain_stage
    import pipe_chain_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             kill_i,
    input  logic             hold_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic             next_valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next-state selection in priority order.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        case (stage_action(rst, kill_i, hold_i))
            ACT_RESET: begin
                valid_d = 1'b0;
                data_d  = '0;
            end
            ACT_KILL: begin
                valid_d = 1'b0;
                data_d  = data_q;
            end
            ACT_HOLD: begin
                valid_d = valid_q;
                data_d  = data_q;
            end
            ACT_PASS: begin
                valid_d = load_i;
                if (load_i) begin
                    data_d = data_i;
                end else begin
                    data_d = data_q;
                end
            end
            default: begin
                valid_d = 1'b0;
                data_d  = '0;
            end
        endcase
    end

    // Slot registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o      = valid_q;
    assign next_valid_o = valid_d;
    assign data_o       = data_q;

endmodule

// File: rtl/pipe_chain.sv
// Generic stallable, flushable pipeline-register chain with ready/valid ends.
// Stage 0 is youngest; empty stages never hold, so bubbles collapse.
module pipe_chain
    import pipe_chain_pkg::*;
#(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned STAGES       = 4,
    parameter int unsigned FLUSH_STAGES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         in_ready,
    input  logic [STAGES-1:0]            stall_req,
    input  logic                         flush,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         out_ready,
    output logic [occ_width(STAGES)-1:0] occupancy,
    output logic [CNT_W-1:0]             bubble_cnt
);

    localparam int unsigned OCC_W = occ_width(STAGES);

    logic [STAGES-1:0] valid_s;
    logic [STAGES-1:0] next_valid_s;
    logic [STAGES-1:0] hold_s;
    logic [STAGES-1:0] move_s;
    logic [STAGES-1:0] load_s;
    logic [STAGES-1:0] kill_s;
    logic [WIDTH-1:0]  data_s [STAGES];
    logic [OCC_W-1:0]  occ_d;
    logic [OCC_W-1:0]  occ_q;
    logic [CNT_W-1:0]  bubble_d;
    logic [CNT_W-1:0]  bubble_q;
    logic              bubble_event_s;

    // Hold ripples from the oldest stage back toward the input.
    always_comb begin : hold_chain
        logic h_s;
        h_s                = valid_s[STAGES-1] & (stall_req[STAGES-1] | ~out_ready);
        hold_s             = '0;
        hold_s[STAGES-1]   = h_s;
        for (int i = int'(STAGES) - 2; i >= 0; i--) begin
            h_s       = valid_s[i] & (stall_req[i] | h_s);
            hold_s[i] = h_s;
        end
    end

    assign move_s   = valid_s & ~hold_s;
    assign in_ready = ~hold_s[0] & ~rst;
    assign load_s   = {move_s[STAGES-2:0], in_valid & in_ready};

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        localparam logic IN_FLUSH_WINDOW = (g < FLUSH_STAGES);
        logic [WIDTH-1:0] src_s;

        if (g == 0) begin : g_head
            assign src_s = in_data;
        end else begin : g_link
            assign src_s = data_s[g-1];
        end

        assign kill_s[g] = flush & IN_FLUSH_WINDOW;

        pipe_chain_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk          (clk),
            .rst          (rst),
            .kill_i       (kill_s[g]),
            .hold_i       (hold_s[g]),
            .load_i       (load_s[g]),
            .data_i       (src_s),
            .valid_o      (valid_s[g]),
            .next_valid_o (next_valid_s[g]),
            .data_o       (data_s[g])
        );
    end

    assign out_valid = valid_s[STAGES-1] & ~stall_req[STAGES-1] & ~rst;
    assign out_data  = data_s[STAGES-1];

    // Occupancy reflects the valid bits the stages are about to hold.
    always_comb begin
        occ_d = '0;
        for (int i = 0; i < int'(STAGES); i++) begin
            occ_d = occ_d + OCC_W'(next_valid_s[i]);
        end
    end

    // A bubble is a ready downstream seeing nothing while work sits in the chain.
    assign bubble_event_s = out_ready & ~out_valid & (|valid_s);

    // Saturating bubble counter next state.
    always_comb begin
        if (bubble_event_s && (bubble_q != {CNT_W{1'b1}})) begin
            bubble_d = bubble_q + CNT_W'(1'b1);
        end else begin
            bubble_d = bubble_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q    <= '0;
            bubble_q <= '0;
        end else begin
            occ_q    <= occ_d;
            bubble_q <= bubble_d;
        end
    end

    assign occupancy  = occ_q;
    assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_pipe_chain.sv
// Scoreboard bench for pipe_chain (WIDTH=32, STAGES=4, FLUSH_STAGES=1).
// Stimulus queues payloads expected to emerge; a monitor pops them on transfers.
module tb_pipe_chain;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic [3:0]  stall_req;
    logic        flush;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic [2:0]  occupancy;
    logic [15:0] bubble_cnt;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [31:0] exp_q [$];

    pipe_chain #(
        .WIDTH        (32),
        .STAGES       (4),
        .FLUSH_STAGES (1),
        .CNT_W        (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .stall_req  (stall_req),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .occupancy  (occupancy),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Monitor: every downstream transfer must match the oldest queued payload.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out actual=%h required=none", out_data);
            end else begin
                chk("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input bit expect_out, output int acc_cyc);
        bit done;
        done    = 1'b0;
        acc_cyc = -1;
        in_valid = 1'b1;
        in_data  = d;
        if (expect_out) exp_q.push_back(d);
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                done    = 1'b1;
                acc_cyc = cyc;
            end
            tick();
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=not_accepted required=accepted data=%h", d);
        end
    endtask

    task automatic check_latency(input string nm, input int acc_cyc);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 12 && !found; k++) begin
            @(negedge clk);
            if (out_valid) found = 1'b1;
        end
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL %s actual=no_out_valid required=out_valid", nm);
        end else begin
            chk(nm, 32'(cyc - acc_cyc), 32'd4);
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick();
        repeat (2) tick();
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int acc;
        rst = 1'b1; in_valid = 1'b0; in_data = 32'h0; stall_req = 4'b0000;
        flush = 1'b0; out_ready = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_bubble", 32'(bubble_cnt), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        tick();

        // Streaming: three back-to-back payloads, four-cycle latency.
        out_ready = 1'b1;
        send(32'h11, 1'b1, acc);
        begin
            int acc0;
            acc0 = acc;
            send(32'h22, 1'b1, acc);
            send(32'h33, 1'b1, acc);
            check_latency("stream_latency", acc0);
        end
        @(negedge clk); chk("stream_b2b_1", 32'(out_valid), 32'd1);
        @(negedge clk); chk("stream_b2b_2", 32'(out_valid), 32'd1);
        @(negedge clk); chk("stream_end", 32'(out_valid), 32'd0);
        tick();
        drain();
        // Three fill cycles count: ready downstream, stages occupied, output empty.
        @(negedge clk); chk("stream_bubble", 32'(bubble_cnt), 32'd3);
        tick();

        // Backpressure: fill to full, then release.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(32'hA0 + 32'(i), 1'b1, acc);
        @(negedge clk);
        chk("bp_occupancy", 32'(occupancy), 32'd4);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        tick();
        drain();
        @(negedge clk); chk("bp_bubble", 32'(bubble_cnt), 32'd3);
        tick();

        // Bubble collapse: two entries parked in stages 2,3 with the output stalled.
        out_ready = 1'b0;
        send(32'h50, 1'b1, acc);
        send(32'h51, 1'b1, acc);
        tick(); tick();
        @(negedge clk); chk("bc_occupancy2", 32'(occupancy), 32'd2);
        tick();
        out_ready = 1'b1; stall_req = 4'b1000;
        send(32'h60, 1'b1, acc);
        send(32'h61, 1'b1, acc);
        @(negedge clk);
        chk("bc_in_ready_full", 32'(in_ready), 32'd0);
        chk("bc_occupancy4", 32'(occupancy), 32'd4);
        tick();
        stall_req = 4'b0000;
        @(negedge clk); chk("bc_bubble", 32'(bubble_cnt), 32'd6);
        tick();
        drain();

        // Mid-pipe stall on stage 1 with a full chain: exactly one output gap.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(32'h70 + 32'(i), 1'b1, acc);
        out_ready = 1'b1; stall_req = 4'b0010;
        @(negedge clk); chk("ms_cyc0", 32'(out_valid), 32'd1);
        tick();
        stall_req = 4'b0000;
        @(negedge clk); chk("ms_cyc1", 32'(out_valid), 32'd1);
        @(negedge clk); chk("ms_gap", 32'(out_valid), 32'd0);
        @(negedge clk); chk("ms_cyc3", 32'(out_valid), 32'd1);
        @(negedge clk); chk("ms_cyc4", 32'(out_valid), 32'd1);
        @(negedge clk); chk("ms_done", 32'(out_valid), 32'd0);
        tick();
        drain();
        @(negedge clk); chk("ms_bubble", 32'(bubble_cnt), 32'd7);
        tick();

        // Flush with a full, blocked chain: youngest occupant dies, 0xC0 refused.
        out_ready = 1'b0;
        send(32'hB3, 1'b1, acc);
        send(32'hB2, 1'b1, acc);
        send(32'hB1, 1'b1, acc);
        send(32'hB0, 1'b0, acc);
        flush = 1'b1; in_valid = 1'b1; in_data = 32'hC0;
        @(negedge clk); chk("fl_in_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk); chk("fl_occupancy", 32'(occupancy), 32'd3);
        tick();
        drain();

        // Flush while moving: accepted input dropped, stage 0 payload escapes.
        send(32'hE0, 1'b1, acc);
        flush = 1'b1; in_valid = 1'b1; in_data = 32'hD0;
        @(negedge clk); chk("fl2_in_ready", 32'(in_ready), 32'd1);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk); chk("fl2_occupancy", 32'(occupancy), 32'd1);
        tick();
        drain();
        @(negedge clk); chk("fl_bubble", 32'(bubble_cnt), 32'd10);
        tick();

        // Reset mid-operation on a full chain.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(32'hF0 + 32'(i), 1'b0, acc);
        rst = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("mrst_in_ready", 32'(in_ready), 32'd0);
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_out_valid_after", 32'(out_valid), 32'd0);
        chk("mrst_occupancy", 32'(occupancy), 32'd0);
        chk("mrst_bubble", 32'(bubble_cnt), 32'd0);
        tick();
        send(32'h99, 1'b1, acc);
        check_latency("mrst_latency", acc);
        tick();
        drain();

        // Saturation: the counter sits at 3 here; park one entry behind a stall.
        stall_req = 4'b1000; out_ready = 1'b1;
        send(32'h5A, 1'b1, acc);
        repeat (65532) tick();
        @(negedge clk); chk("sat_reach", 32'(bubble_cnt), 32'h0000FFFF);
        tick();
        repeat (5) tick();
        @(negedge clk); chk("sat_hold", 32'(bubble_cnt), 32'h0000FFFF);
        tick();
        stall_req = 4'b0000;
        drain();

        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
